chr_bank_cache: RTL

CHR_BANK_CACHE -- requirements
Module: chr_bank_cache

---
 rtl/chr_bank_cache.sv | 139 +++++++++++++
 1 files changed

// File: rtl/chr_bank_cache.sv
`timescale 1ns/1ps
// CHR bank cache: holds one 8 KB CHR page in on-chip RAM.
// The PPU side reads it without stalls. A loader FSM refills the RAM from the
// memory controller, one word per request. A refill starts whenever the mapper
// page changes or init_req is pulsed.
module chr_bank_cache #(
  parameter int unsigned WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  page,
  input  logic        init_req,
  input  logic [12:0] chr_addr,
  output logic [7:0]  chr_data,
  output logic        req,
  input  logic        req_ack,
  input  logic        ready,
  input  logic [15:0] from_mem,
  output logic [19:0] mem_addr,
  output logic        busy
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [11:0] LAST_WORD = 12'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_latched_q, page_latched_d;
  logic [7:0]  loaded_page_q, loaded_page_d;
  logic        loaded_valid_q, loaded_valid_d;
  logic        restart_q, restart_d;
  logic [11:0] word_cnt_q, word_cnt_d;
  logic [7:0]  chr_data_q;
  logic        req_d;
  logic        ram_we;
  logic        pending;
  logic        restart_now;
  logic [15:0] rd_word;

  logic [15:0] ram [WORDS];

  // A refill is owed when nothing valid is loaded, the mapper moved, or a refill was forced
  assign pending     = init_req | ~loaded_valid_q | (page != loaded_page_q);
  // A mid-refill page change or init request restarts the current pass
  assign restart_now = init_req | (page != page_latched_q);

  // Loader FSM next-state logic and request strobe
  always_comb begin
    state_d        = state_q;
    page_latched_d = page_latched_q;
    loaded_page_d  = loaded_page_q;
    loaded_valid_d = loaded_valid_q;
    restart_d      = restart_q;
    word_cnt_d     = word_cnt_q;
    req_d          = 1'b0;
    ram_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          page_latched_d = page;
          word_cnt_d     = '0;
          loaded_valid_d = 1'b0;
          restart_d      = 1'b0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        req_d = 1'b1;
        if (restart_now) restart_d = 1'b1;
        if (req_ack) state_d = WAIT;
      end
      WAIT: begin
        if (restart_now) restart_d = 1'b1;
        if (ready) begin
          // The in-flight word is always written, even when the pass is being restarted
          ram_we = 1'b1;
          if (restart_q | restart_now) begin
            page_latched_d = page;
            word_cnt_d     = '0;
            restart_d      = 1'b0;
            state_d        = ISSUE;
          end else if (word_cnt_q == LAST_WORD) begin
            loaded_page_d  = page_latched_q;
            loaded_valid_d = 1'b1;
            word_cnt_d     = '0;
            state_d        = IDLE;
          end else begin
            word_cnt_d     = word_cnt_q + 12'd1;
            state_d        = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader FSM and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      page_latched_q <= '0;
      loaded_page_q  <= '0;
      loaded_valid_q <= 1'b0;
      restart_q      <= 1'b0;
      word_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      page_latched_q <= page_latched_d;
      loaded_page_q  <= loaded_page_d;
      loaded_valid_q <= loaded_valid_d;
      restart_q      <= restart_d;
      word_cnt_q     <= word_cnt_d;
    end
  end

  // Loader write port. Nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[word_cnt_q[AW-1:0]] <= from_mem;
  end

  assign rd_word = ram[chr_addr[AW:1]];

  // PPU read port: byte select registered one clock after the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chr_data_q <= '0;
    else     chr_data_q <= chr_addr[0] ? rd_word[15:8] : rd_word[7:0];
  end

  assign chr_data = chr_data_q;
  assign req      = req_d;
  assign mem_addr = {page_latched_q, word_cnt_q};
  assign busy     = (state_q != IDLE) | pending;

endmodule
